result_display: RTL and testbench

//   Downstream stage of the calculator adder. Captures the 8-bit unsigned result
//   on a load pulse and converts it to 3-digit BCD with a sequential double-dabble
//   (one shift-add-3 iteration per clock). It then drives a 4-digit, active-low,

---
 rtl/result_display_if.sv | 12 +
 rtl/result_display.sv | 98 +++++++++
 tb/tb_result_display.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/result_display_if.sv
// result_display_if: adder-result input and BCD/7-segment display outputs of result_display
interface result_display_if;
    logic [7:0]  result;
    logic        load;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    modport master(output result, load, input busy, bcd, seg, an, dp);
    modport slave(input result, load, output busy, bcd, seg, an, dp);
endinterface

// File: rtl/result_display.sv
// result_display: latch adder result, convert to BCD by sequential double-dabble, scan a 4-digit 7-seg display
module result_display #(
    parameter int CLK_DIV = 100000
) (
    input logic clk,
    input logic rst,
    result_display_if.slave d
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    state_t        state, state_n;
    logic [19:0]   shreg, shreg_n, adj;
    logic [2:0]    iter, iter_n;
    logic [11:0]   bcd_q, bcd_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sel, sel_n;
    logic [3:0]    digit;
    logic          wrap, blank;
    logic [6:0]    seg_q, seg_n;
    logic [3:0]    an_q;
    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            default: dec = 7'b0010000;
        endcase
    endfunction
    assign adj = {shreg[19:16] >= 4'd5 ? shreg[19:16] + 4'd3 : shreg[19:16],
                  shreg[15:12] >= 4'd5 ? shreg[15:12] + 4'd3 : shreg[15:12],
                  shreg[11:8]  >= 4'd5 ? shreg[11:8]  + 4'd3 : shreg[11:8],
                  shreg[7:0]};
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        iter_n  = iter;
        bcd_n   = bcd_q;
        case (state)
            IDLE: if (d.load) begin
                shreg_n = {12'b0, d.result};
                iter_n  = 3'd0;
                state_n = CONVERT;
            end
            CONVERT: begin
                shreg_n = {adj[18:0], 1'b0};
                iter_n  = iter + 3'd1;
                state_n = iter == 3'd7 ? DONE : CONVERT;
            end
            DONE: begin
                bcd_n   = shreg[19:8];
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // seg is built from the next sel and next bcd so it always matches the registered an
    always_comb begin
        wrap  = cnt == CW'(CLK_DIV - 1);
        cnt_n = wrap ? '0 : cnt + CW'(1);
        sel_n = wrap ? sel + 2'd1 : sel;
        digit = sel_n == 2'd0 ? bcd_n[3:0] : sel_n == 2'd1 ? bcd_n[7:4] : bcd_n[11:8];
        blank = sel_n == 2'd3 || (sel_n == 2'd2 && bcd_n[11:8] == 4'd0) ||
                (sel_n == 2'd1 && bcd_n[11:4] == 8'd0);
        seg_n = blank ? 7'b1111111 : dec(digit);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            iter  <= '0;
            bcd_q <= '0;
            cnt   <= '0;
            sel   <= '0;
            an_q  <= 4'b1110;
            seg_q <= 7'b1000000;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            iter  <= iter_n;
            bcd_q <= bcd_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
            an_q  <= ~(4'b0001 << sel_n);
            seg_q <= seg_n;
        end
    end
    assign d.busy = state != IDLE;
    assign d.bcd  = bcd_q;
    assign d.seg  = seg_q;
    assign d.an   = an_q;
    assign d.dp   = 1'b1;
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: randomized scoreboard bench for result_display against an arithmetic reference model
module tb_result_display;
    localparam int DIV = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    result_display_if ifc();
    result_display #(.CLK_DIV(DIV)) dut(.clk(clk), .rst(rst), .d(ifc));
    always #5 clk = ~clk;
    int n = 0;
    int done_at = 0;
    bit mbusy = 1'b0;
    logic [11:0] mbcd = '0;
    logic [11:0] mpend = '0;
    int q_bcd[$];
    int q_at[$];
    bit prev_busy = 1'b0;
    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction
    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int s);
        int h, t, o;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        o = int'(b[3:0]);
        if (s == 3 || (s == 2 && h == 0) || (s == 1 && h == 0 && t == 0)) return 7'b1111111;
        return segtab[s == 0 ? o : s == 1 ? t : h];
    endfunction
    // reference model: a conversion accepted at edge n completes at edge n+9
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n = 0;
                mbusy = 1'b0;
                mbcd = '0;
                q_bcd.delete();
                q_at.delete();
            end else begin
                n++;
                if (mbusy && n == done_at) begin
                    mbcd = mpend;
                    mbusy = 1'b0;
                end else if (!mbusy && ifc.load) begin
                    mbusy = 1'b1;
                    mpend = to_bcd(int'(ifc.result));
                    done_at = n + 9;
                    q_bcd.push_back(int'(mpend));
                    q_at.push_back(done_at);
                end
            end
        end
    end
    initial begin
        logic [3:0] ea;
        int s, eb, et;
        forever begin
            @(negedge clk);
            if (rst) prev_busy = 1'b0;
            else begin
                s = (n / DIV) % 4;
                ea = ~(4'b0001 << s);
                chk("busy", 32'(ifc.busy), 32'(mbusy));
                chk("bcd", 32'(ifc.bcd), 32'(mbcd));
                chk("an", 32'(ifc.an), 32'(ea));
                chk("seg", 32'(ifc.seg), 32'(exp_seg(mbcd, s)));
                chk("dp", 32'(ifc.dp), 32'd1);
                if (prev_busy && !ifc.busy) begin
                    if (q_bcd.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done_unexpected actual=%h required=none t=%0t", ifc.bcd, $time);
                    end else begin
                        eb = q_bcd.pop_front();
                        et = q_at.pop_front();
                        chk("done_bcd", 32'(ifc.bcd), 32'(eb));
                        chk("done_edge", 32'(n), 32'(et));
                    end
                end
                prev_busy = ifc.busy;
            end
        end
    end
    task automatic do_load(input logic [7:0] v);
        ifc.result = v;
        ifc.load = 1'b1;
        @(negedge clk);
        ifc.load = 1'b0;
        ifc.result = 8'($urandom);
    endtask
    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
    initial begin
        int g;
        ifc.result = 8'd0;
        ifc.load = 1'b0;
        idle(2);
        #1;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_bcd", 32'(ifc.bcd), 32'h000);
        chk("rst_an", 32'(ifc.an), 32'b1110);
        chk("rst_seg", 32'(ifc.seg), 32'b1000000);
        chk("rst_dp", 32'(ifc.dp), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        do_load(8'd255);
        idle(20);
        do_load(8'd0);
        idle(20);
        do_load(8'd100);
        idle(20);
        do_load(8'd7);
        idle(20);
        do_load(8'd30);
        idle(1);
        do_load(8'd99);
        idle(14);
        do_load(8'd99);
        idle(14);
        do_load(8'd200);
        idle(4);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_bcd", 32'(ifc.bcd), 32'h000);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        do_load(8'd17);
        idle(14);
        idle(32);
        for (int i = 0; i < 40; i++) begin
            do_load(8'($urandom_range(0, 255)));
            g = $urandom_range(0, 14);
            repeat (g) begin
                ifc.load = $urandom_range(0, 4) == 0;
                ifc.result = 8'($urandom);
                @(negedge clk);
            end
            ifc.load = 1'b0;
        end
        for (int i = 0; i < 200 && (mbusy || q_bcd.size() != 0); i++) @(negedge clk);
        idle(3);
        chk("drain", 32'(q_bcd.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
